// File: rtl/arb10_pkg.sv
// arb10_pkg: shared types, constants and the round-robin mask helper
// for the 10-way arbiter (arb10_ctrl, arb10_prio_enc).
package arb10_pkg;

  localparam int N_REQ = 10;
  localparam logic [3:0] ID_MAX = 4'd9;

  typedef logic [9:0] req_vec_t;
  typedef logic [3:0] bcd_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Bits strictly below ptr: searched first, highest first,
  // giving the order ptr-1 .. 0 before wrapping to 9 .. ptr.
  function automatic req_vec_t rotate_mask(bcd_id_t ptr);
    req_vec_t m;
    m = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i < int'(ptr)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/arb10_prio_enc.sv
// arb10_prio_enc: 10->4 priority encoder, highest index wins.
// Ports: req (in, 10), id (out, BCD 0-9), valid (out, any req set).
module arb10_prio_enc
  import arb10_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [3:0]       id,
  output logic             valid
);

  // Ascending scan: the last set bit seen is the highest.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        id    = bcd_id_t'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb10_ctrl.sv
// arb10_ctrl: 10-requester arbiter, fixed or round-robin, grant hold.
// Ports: clk, rst_n (async low), en, mode_sel, req[10] in;
//   gnt[10], gnt_id[4], gnt_valid, gnt_cnt[CNT_W], timeout out.
// Optional hold limit with forced release: define ARB_TIMEOUT_EN.
module arb10_ctrl
  import arb10_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode_sel,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [3:0]       gnt_id,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] gnt_cnt,
  output logic             timeout
);

  arb_state_e state_q, state_d;
  req_vec_t   gnt_q, gnt_d;
  bcd_id_t    id_q, id_d;
  bcd_id_t    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bcd_id_t m_id, a_id, win;
  logic    m_valid, a_valid;
  logic    held, hold_hit, release_g;

  arb10_prio_enc u_enc_m (
    .req   (req & rotate_mask(ptr_q)),
    .id    (m_id),
    .valid (m_valid)
  );

  arb10_prio_enc u_enc_a (
    .req   (req),
    .id    (a_id),
    .valid (a_valid)
  );

  // Masked hit first; otherwise wrap to the full vector.
  assign win = (mode_sel && m_valid) ? m_id : a_id;

  assign held = |(req & gnt_q);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold_q, hold_d;
  logic        to_q, to_d;
  assign hold_hit = held &&
    (hold_q == 16'(MAX_HOLD - 1));
  assign timeout  = to_q;
`else
  assign hold_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign release_g = !en || !held || hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && a_valid) state_d = GRANT;
      GRANT:   if (release_g) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    id_d  = id_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
`ifdef ARB_TIMEOUT_EN
    hold_d = hold_q;
    to_d   = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (en && a_valid) begin
        gnt_d      = '0;
        gnt_d[win] = 1'b1;
        id_d       = win;
        ptr_d      = win;
        cnt_d      = (&cnt_q) ? cnt_q
                   : cnt_q + CNT_W'(1);
`ifdef ARB_TIMEOUT_EN
        hold_d = '0;
`endif
      end
    end else if (release_g) begin
      gnt_d = '0;
      id_d  = '0;
`ifdef ARB_TIMEOUT_EN
      to_d  = hold_hit;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      hold_d = hold_q + 16'd1;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == GRANT);
  assign gnt_cnt   = cnt_q;

endmodule

// File: doc/arb10_ctrl.md
Name: arb10_ctrl

Overview:
- Sequential arbiter for up to 10 requesters sharing one resource.
- Each cycle in IDLE, the 10-bit request vector goes through the team's priority-encoding function. Winner index (0–9) is registered as a one-hot grant plus a 4-bit BCD id.
- Two modes, selected by mode_sel: fixed priority (index 9 highest) or round-robin (rotating priority).
- Sits in front of any shared datapath resource; replaces the combinational normal/priority encoder front-end where fairness and grant hold are required.

Parameters:
- N_REQ, 10, requester count; fixed at 10 (BCD id range 0–9); other values unsupported.
- CNT_W, 16, width of the saturating grant counter.
- MAX_HOLD, 64, max consecutive grant cycles before forced release (used only with ARB_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable.
- mode_sel  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- req  in  10  request lines, level-sensitive; a requester holds its bit high for as long as it needs the grant.
- gnt  out  10  one-hot grant, registered.
- gnt_id  out  4  BCD index of the granted requester (0–9), registered.
- gnt_valid  out  1  high while any grant is active.
- gnt_cnt  out  CNT_W  number of grants issued; saturates at all-ones.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n low, async): gnt=0, gnt_id=0, gnt_valid=0, gnt_cnt=0, timeout=0, state=IDLE, rr_ptr=0.
- States are IDLE and GRANT.
- IDLE → GRANT:
  - Condition: en=1 and req≠0.
  - The winner is registered on that clock edge, so gnt appears 1 cycle after req is sampled.
  - gnt_cnt increments on the same edge, saturating.
- Fixed mode: the highest-index set bit wins.
- Round-robin mode:
  - Search order is rr_ptr-1, rr_ptr-2, …, 0, 9, …, rr_ptr (descending, wrapping 0→9).
  - rr_ptr loads the winner id on every grant, in both modes.
  - Since rr_ptr resets to 0, the first RR order is 9..0, identical to fixed mode.
- GRANT:
  - gnt, gnt_id and gnt_valid are held stable.
  - Changes on req bits other than the granted one are ignored.
- GRANT → IDLE occurs when any of these is seen:
  - req[gnt_id]=0, or
  - en=0, or
  - the hold limit is reached (with ARB_TIMEOUT_EN only).
- On that edge, gnt, gnt_valid and gnt_id are cleared. The id clears to 0.
- At least one idle cycle always separates consecutive grants, including a re-grant to the same requester.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is considered only in the following IDLE cycle.
  - en=0 in IDLE blocks arbitration; req is not latched.
- mode_sel changes during GRANT have no effect until the next IDLE.
- rst_n asserted mid-grant: gnt drops immediately (async); gnt_cnt returns to 0.
- Never more than one gnt bit high; gnt_id always equals the index of the set bit, or 0 when gnt=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A hold counter clears on entry to GRANT and counts each cycle in GRANT.
  - When it reaches MAX_HOLD-1 with req[gnt_id] still high, the grant is forcibly released on the next edge and timeout pulses high for that 1 cycle.
  - In RR mode the timed-out requester automatically drops to lowest priority.
- When undefined: no hold counter; a grant lasts indefinitely; the timeout port is tied 0.

Decomposition:
- Package arb10_pkg holds:
  - typedef req_vec_t = logic [9:0];
  - typedef bcd_id_t = logic [3:0];
  - enum arb_state_e {IDLE, GRANT};
  - constants N_REQ=10, ID_MAX=4'd9;
  - function rotate_mask(ptr) returning the RR search mask.
- One sub-module, arb10_prio_enc: combinational 10→4 priority encoder (highest index wins) with a valid output. It is instantiated twice, once on the masked request vector and once on the unmasked vector, to implement the RR wrap.

Test Plan:
- Reset then fixed mode, req=10'h201 held → after 1 cycle gnt=10'h200, gnt_id=9, gnt_valid=1, gnt_cnt=1; drop req[9] → next cycle gnt=0; after 1 idle cycle gnt_id=0.
- RR mode, req=10'h3FF held, each winner drops its bit 2 cycles after grant then reasserts → grant sequence 9,8,7,…,0,9; gnt_cnt=11 after 11 grants.
- en=0 during GRANT (id 5) → gnt=0 next cycle; en=0 in IDLE with req=10'h010 → no grant until en=1.
- rst_n pulsed low mid-grant asynchronously, between clock edges → gnt=0, gnt_valid=0 without a clock edge; gnt_cnt=0; first RR grant afterwards uses order 9..0.
- mode_sel toggled 0→1 during an id-3 grant with req=10'h018 → the id-3 grant is unaffected; next grant uses RR order from rr_ptr=3: winner id 2 if present, else wrap to 4 (id 4 wins).
- With ARB_TIMEOUT_EN, MAX_HOLD=4, req[6] held high → gnt for exactly 4 cycles, timeout=1 for 1 cycle, 1 idle cycle, then re-grant to id 6 if it is the only requester.
